// File: rtl/image_pkg.sv
// Shared definitions for the image front-end blocks.
// Holds the default frame geometry, the pixel quantisation width, the
// output FSM state type and the quantiser used by pixel_packer.
package image_pkg;

    localparam int LINE_PIXELS    = 184;
    localparam int LINE_COUNT     = 36;
    localparam int WORDS_PER_LINE = LINE_PIXELS / 2;
    localparam int FIFO_DEPTH     = 256;
    localparam int QBITS          = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } pp_state_t;

    // Keep the top QBITS bits of a grey level (truncation, no rounding).
    function automatic logic [QBITS-1:0] quantise(input logic [7:0] pix);
        return pix[7:8-QBITS];
    endfunction

endpackage

// File: rtl/pixel_packer_if.sv
// Pixel stream in / packed word stream out for pixel_packer.
//   pix_in, pix_valid, pix_sof : upstream pixel, its valid, start-of-frame
//   pix_ready                  : packer can accept a pixel
//   data4sr, data4sr_valid     : packed pair burst towards the shift registers
//   frame_done                 : pulse after the last word of a frame
//   sof_err                    : sticky misplaced start-of-frame flag
// master = source/sink around the packer, slave = the packer itself.
interface pixel_packer_if;
    import image_pkg::*;

    logic [7:0]         pix_in;
    logic               pix_valid;
    logic               pix_sof;
    logic               pix_ready;
    logic [2*QBITS-1:0] data4sr;
    logic               data4sr_valid;
    logic               frame_done;
    logic               sof_err;

    modport master (
        output pix_in, pix_valid, pix_sof,
        input  pix_ready, data4sr, data4sr_valid, frame_done, sof_err
    );

    modport slave (
        input  pix_in, pix_valid, pix_sof,
        output pix_ready, data4sr, data4sr_valid, frame_done, sof_err
    );

endinterface

// File: rtl/pix_fifo.sv
// Single-clock FIFO for packed pixel pairs with line-boundary rewind.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push, wdata : write one word
//   pop, rdata  : rdata shows the head word; pop advances past it
//   mark        : remember the write pointer after this cycle's push
//   rewind      : move the write pointer back to the remembered position
//   count       : registered number of stored words
module pix_fifo import image_pkg::*; #(
    parameter int WIDTH = 2 * QBITS,
    parameter int DEPTH = image_pkg::FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    input  logic             mark,
    input  logic             rewind,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, mark_ptr;
    logic [AW:0]      wr_base, wr_next, rd_next;

    // A rewind takes effect before any push of the same cycle.
    always_comb begin
        wr_base = rewind ? mark_ptr : wr_ptr;
        wr_next = wr_base + (AW+1)'(push);
        rd_next = rd_ptr + (AW+1)'(pop);
    end

    // Count comes from the updated pointers, so push+pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mark_ptr <= '0;
            count    <= '0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            count  <= wr_next - rd_next;
            if (mark) begin
                mark_ptr <= wr_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_base[AW-1:0]] <= wdata;
        end
    end

    // Write-first: a word pushed into an empty FIFO is visible at once.
    assign rdata = (push && count == '0) ? wdata : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pixel_packer.sv
// Quantises 8-bit grey pixels to QBITS, packs two per word into a FIFO and
// releases each image line as one gap-free burst of LINE_PIXELS/2 words.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pixel_packer_if.slave (pixel input, packed burst output,
//              frame_done pulse, sticky sof_err)
module pixel_packer import image_pkg::*; #(
    parameter int LINE_PIXELS = image_pkg::LINE_PIXELS,
    parameter int LINE_COUNT  = image_pkg::LINE_COUNT,
    parameter int FIFO_DEPTH  = image_pkg::FIFO_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    pixel_packer_if.slave  bus
);

    localparam int WORDS = LINE_PIXELS / 2;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PCW   = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
    localparam int LCW   = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;
    localparam int BCW   = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [PCW-1:0] PIX_LAST   = PCW'(LINE_PIXELS - 1);
    localparam logic [LCW-1:0] LINE_LAST  = LCW'(LINE_COUNT - 1);
    localparam logic [BCW-1:0] BURST_LAST = BCW'(WORDS - 1);
    localparam logic [AW:0]    LINE_WORDS = (AW+1)'(WORDS);
    localparam logic [AW:0]    FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    // Input side
    logic                 phase;
    logic [QBITS-1:0]     half_reg;
    logic [PCW-1:0]       in_pix_cnt, pix_base;
    logic [LCW-1:0]       in_line_cnt, line_base;
    logic                 accept, eff_phase, push, rewind, line_end;
    logic                 sof_err_reg;
    logic [QBITS-1:0]     q;

    // Output side
    pp_state_t            state, next_state;
    logic [BCW-1:0]       burst_cnt;
    logic [LCW-1:0]       line_cnt;
    logic                 pop, burst_last, wrap_pend;
    logic [2*QBITS-1:0]   fifo_rdata, data_reg;
    logic                 valid_reg, frame_done_reg;
    logic [AW:0]          fifo_count;

    assign q = quantise(bus.pix_in);

    // Ready uses the registered count; a half-pair never needs space but
    // still waits for a free word so the odd pixel can always be stored.
    assign bus.pix_ready = !rst && (fifo_count < FULL_COUNT);

    // Start-of-frame restarts pairing and counting at this pixel. If data of
    // an unfinished line is outstanding, that line is dropped from the FIFO.
    always_comb begin
        accept    = bus.pix_valid && bus.pix_ready;
        eff_phase = phase && !bus.pix_sof;
        pix_base  = bus.pix_sof ? '0 : in_pix_cnt;
        line_base = bus.pix_sof ? '0 : in_line_cnt;
        push      = accept && eff_phase;
        line_end  = accept && (pix_base == PIX_LAST);
        rewind    = accept && bus.pix_sof &&
                    (phase || in_pix_cnt != '0 || in_line_cnt != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= 1'b0;
            half_reg    <= '0;
            in_pix_cnt  <= '0;
            in_line_cnt <= '0;
            sof_err_reg <= 1'b0;
        end else if (accept) begin
            phase <= !eff_phase;
            if (!eff_phase) begin
                half_reg <= q;
            end
            if (rewind) begin
                sof_err_reg <= 1'b1;
            end
            if (pix_base == PIX_LAST) begin
                in_pix_cnt  <= '0;
                in_line_cnt <= (line_base == LINE_LAST) ? '0 : line_base + 1'b1;
            end else begin
                in_pix_cnt  <= pix_base + 1'b1;
                in_line_cnt <= line_base;
            end
        end
    end

    pix_fifo #(
        .WIDTH (2 * QBITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wdata  ({q, half_reg}),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .mark   (line_end),
        .rewind (rewind),
        .count  (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A burst only starts with a whole line buffered, so it cannot starve;
    // returning to WAIT after each line guarantees one idle cycle between lines.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        burst_last = 1'b0;
        case (state)
            IDLE: next_state = WAIT;
            WAIT: begin
                if (fifo_count >= LINE_WORDS) begin
                    next_state = BURST;
                end
            end
            BURST: begin
                pop = 1'b1;
                if (burst_cnt == BURST_LAST) begin
                    burst_last = 1'b1;
                    next_state = WAIT;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from the word popped this cycle; frame_done
    // is delayed one extra cycle so it lands just after the final word.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt      <= '0;
            line_cnt       <= '0;
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            wrap_pend      <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            valid_reg      <= (state == BURST);
            data_reg       <= (state == BURST) ? fifo_rdata : '0;
            burst_cnt      <= (state == BURST && !burst_last) ? burst_cnt + 1'b1 : '0;
            wrap_pend      <= burst_last && (line_cnt == LINE_LAST);
            frame_done_reg <= wrap_pend;
            if (burst_last) begin
                line_cnt <= (line_cnt == LINE_LAST) ? '0 : line_cnt + 1'b1;
            end
        end
    end

    assign bus.data4sr       = data_reg;
    assign bus.data4sr_valid = valid_reg;
    assign bus.frame_done    = frame_done_reg;
    assign bus.sof_err       = sof_err_reg;

endmodule
